// File: rtl/vga_pkg.sv
// Shared types and default 800x600@56Hz SVGA timing for the VGA raster generator.
package vga_pkg;

   localparam int unsigned COORD_W = 10;

   // 800x600@56Hz, 36 MHz pixel clock: 1024 x 625 total raster
   localparam int unsigned SVGA_H_ACTIVE = 800;
   localparam int unsigned SVGA_H_FP     = 24;
   localparam int unsigned SVGA_H_SYNC   = 72;
   localparam int unsigned SVGA_H_BP     = 128;
   localparam int unsigned SVGA_V_ACTIVE = 600;
   localparam int unsigned SVGA_V_FP     = 1;
   localparam int unsigned SVGA_V_SYNC   = 2;
   localparam int unsigned SVGA_V_BP     = 22;

   typedef logic [COORD_W-1:0] coord_t;

   // Raw control bits are active-high internally; pin polarity is applied at the output
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } vga_ctl_t;

   localparam vga_ctl_t CTL_IDLE = '{hs: 1'b0, vs: 1'b0, de: 1'b0};

   // True when c lies in [lo, lo+len-1]
   function automatic logic in_window(coord_t c, int unsigned lo, int unsigned len);
      return (32'(c) >= lo) && (32'(c) < lo + len);
   endfunction

endpackage

// File: rtl/vga_ctl_delay.sv
// Resettable shift register aligning raw sync/blank with the renderer's colour latency.
module vga_ctl_delay
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic     pixel_clk,
   input  logic     rst_n,
   input  vga_ctl_t ctl_i,
   output vga_ctl_t ctl_o
);

   if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = pixel_clk ^ rst_n;
      assign ctl_o = ctl_i;
   end else begin : g_pipe
      vga_ctl_t stage_q [DEPTH];

      // Shift raw control down the pipe; reset clears every stage to blank, sync inactive
      always_ff @(posedge pixel_clk) begin
         if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               stage_q[i] <= CTL_IDLE;
            end
         end else begin
            stage_q[0] <= ctl_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign ctl_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, sync decode, latency-matched pin registers, frame count.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
   parameter int unsigned H_FP     = SVGA_H_FP,
   parameter int unsigned H_SYNC   = SVGA_H_SYNC,
   parameter int unsigned H_BP     = SVGA_H_BP,
   parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
   parameter int unsigned V_FP     = SVGA_V_FP,
   parameter int unsigned V_SYNC   = SVGA_V_SYNC,
   parameter int unsigned V_BP     = SVGA_V_BP,
   parameter logic        SYNC_POL = 1'b1,
   parameter int unsigned PIPE_LAT = 1
) (
   input  logic               pixel_clk,
   input  logic               rst_n,
   output logic [COORD_W-1:0] h_coord,
   output logic [COORD_W-1:0] v_coord,
   output logic               display_on,
   output logic               end_of_frame,
   output logic [15:0]        frame_cnt,
   input  logic [3:0]         red,
   input  logic [3:0]         green,
   input  logic [3:0]         blue,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic [3:0]         vga_r,
   output logic [3:0]         vga_g,
   output logic [3:0]         vga_b
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   coord_t      h_q, h_d, v_q, v_d;
   logic        h_last, v_last;
   logic        eof_q, eof_d;
   logic [15:0] fcnt_q, fcnt_d;
   vga_ctl_t    ctl_raw, ctl_dly;
   logic        hs_q, vs_q;
   logic [11:0] rgb_q;

   // Next-state for raster counters; v and frame count only advance on the h wrap
   always_comb begin
      h_last = (32'(h_q) == H_TOTAL - 1);
      v_last = (32'(v_q) == V_TOTAL - 1);
      h_d    = h_last ? '0 : h_q + coord_t'(1);
      v_d    = v_q;
      if (h_last) begin
         v_d = v_last ? '0 : v_q + coord_t'(1);
      end
      eof_d  = h_last && v_last;
      fcnt_d = eof_d ? fcnt_q + 16'd1 : fcnt_q;
   end

   // Raster counter, end-of-frame and frame count registers
   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         h_q    <= '0;
         v_q    <= '0;
         eof_q  <= 1'b0;
         fcnt_q <= '0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         eof_q  <= eof_d;
         fcnt_q <= fcnt_d;
      end
   end

   // Undelayed sync/blank decode straight from the counters
   always_comb begin
      ctl_raw    = CTL_IDLE;
      ctl_raw.hs = in_window(h_q, H_ACTIVE + H_FP, H_SYNC);
      ctl_raw.vs = in_window(v_q, V_ACTIVE + V_FP, V_SYNC);
      ctl_raw.de = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
   end

   vga_ctl_delay #(
      .DEPTH (PIPE_LAT)
   ) u_ctl_delay (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .ctl_i     (ctl_raw),
      .ctl_o     (ctl_dly)
   );

   // Pin registers: the extra stage here makes every pin PIPE_LAT+1 behind the coords
   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         hs_q  <= ~SYNC_POL;
         vs_q  <= ~SYNC_POL;
         rgb_q <= '0;
      end else begin
         hs_q  <= ~(ctl_dly.hs ^ SYNC_POL);
         vs_q  <= ~(ctl_dly.vs ^ SYNC_POL);
         rgb_q <= ctl_dly.de ? {red, green, blue} : 12'h000;
      end
   end

   assign h_coord      = h_q;
   assign v_coord      = v_q;
   assign display_on   = ctl_raw.de;
   assign end_of_frame = eof_q;
   assign frame_cnt    = fcnt_q;
   assign vga_hs       = hs_q;
   assign vga_vs       = vs_q;
   assign vga_r        = rgb_q[11:8];
   assign vga_g        = rgb_q[7:4];
   assign vga_b        = rgb_q[3:0];

endmodule
